// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into one in-order register
// bank write stream, with an optional youngest-match bypass lookup.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   alu_* / mem_*        valid/ready producer ports (dr, signed data)
//   write, dr, wrData    register bank write port (head of queue)
//   sr1, sr2             bypass lookup source registers
//   fwd{1,2}_hit/_data   bypass results
//   count, full, empty   queue status
//
// Optional feature: define WB_BYPASS_EN to build the bypass lookup;
// otherwise the fwd outputs are tied to 0.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_dr,
  input  logic signed [31:0]         alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_dr,
  input  logic signed [31:0]         mem_data,
  output logic                       write,
  output logic [4:0]                 dr,
  output logic signed [31:0]         wrData,
  input  logic [4:0]                 sr1,
  input  logic [4:0]                 sr2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic signed [31:0]         fwd1_data,
  output logic signed [31:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  logic [4:0]         q_dr   [DEPTH];
  logic signed [31:0] q_data [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;

  logic alu_push;
  logic mem_push;
  logic deq;
  logic [AW-1:0] mem_slot;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // No credit is given for the dequeue happening in the same cycle.
  assign alu_ready = (count < CNT_FULL);
  // MEM may take the last free slot only when ALU is not competing for it.
  assign mem_ready = (count < CNT_LAST) ||
                     ((count < CNT_FULL) && !alu_valid);

  // dr == 0 transfers complete the handshake but never occupy a slot.
  assign alu_push = alu_valid && alu_ready && (alu_dr != 5'd0);
  assign mem_push = mem_valid && mem_ready && (mem_dr != 5'd0);
  assign deq      = !empty;

  // ALU entry goes ahead of the MEM entry when both arrive together.
  assign mem_slot = wr_ptr + AW'(alu_push);

  assign write  = !empty;
  assign dr     = empty ? 5'd0  : q_dr[rd_ptr];
  assign wrData = empty ? 32'sd0 : q_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (alu_push) begin
        q_dr[wr_ptr]   <= alu_dr;
        q_data[wr_ptr] <= alu_data;
      end
      if (mem_push) begin
        q_dr[mem_slot]   <= mem_dr;
        q_data[mem_slot] <= mem_data;
      end
      wr_ptr <= wr_ptr + AW'(alu_push) + AW'(mem_push);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count + (AW+1)'(alu_push) + (AW+1)'(mem_push)
                - (AW+1)'(deq);
    end
  end

`ifdef WB_BYPASS_EN
  // Walks oldest to youngest so the last match (youngest) wins.
  // Only start-of-cycle contents are visible.
  function automatic logic [32:0] lookup(input logic [4:0] sr);
    logic [32:0] res;
    logic [AW-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (((AW+1)'(k) < count) && (sr != 5'd0) && (q_dr[idx] == sr))
        res = {1'b1, q_data[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(sr1);
    {fwd2_hit, fwd2_data} = lookup(sr2);
  end
`else
  logic unused_sr;
  assign unused_sr = ^{sr1, sr2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = 32'sd0;
  assign fwd2_data = 32'sd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios plus randomized traffic
// checked each cycle against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic alu_valid, mem_valid;
  logic alu_ready, mem_ready;
  logic [4:0] alu_dr, mem_dr;
  logic signed [31:0] alu_data, mem_data;
  logic write;
  logic [4:0] dr;
  logic signed [31:0] wrData;
  logic [4:0] sr1, sr2;
  logic fwd1_hit, fwd2_hit;
  logic signed [31:0] fwd1_data, fwd2_data;
  logic [2:0] count;
  logic full, empty;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_dr(alu_dr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dr(mem_dr), .mem_data(mem_data),
    .write(write), .dr(dr), .wrData(wrData),
    .sr1(sr1), .sr2(sr2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] r;
    logic signed [31:0] d;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit last_alu_rdy, last_mem_rdy;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_fwd(input logic [4:0] sr);
    logic [32:0] r;
    r = '0;
`ifdef WB_BYPASS_EN
    foreach (q[i])
      if (sr != 5'd0 && q[i].r == sr) r = {1'b1, q[i].d};
`endif
    return r;
  endfunction

  task automatic check_model();
    int n;
    logic [32:0] f1, f2;
    n = q.size();
    f1 = ref_fwd(sr1);
    f2 = ref_fwd(sr2);
    chk("alu_ready", alu_ready, n < DEPTH);
    chk("mem_ready", mem_ready,
        (n < DEPTH - 1) || (n < DEPTH && !alu_valid));
    chk("count", count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("write", write, n != 0);
    chk("dr", dr, (n != 0) ? q[0].r : 5'd0);
    chk("wrData", wrData, (n != 0) ? q[0].d : 32'sd0);
    chk("fwd1_hit", fwd1_hit, f1[32]);
    chk("fwd1_data", fwd1_data, f1[31:0]);
    chk("fwd2_hit", fwd2_hit, f2[32]);
    chk("fwd2_data", fwd2_data, f2[31:0]);
    chk("count_max", count <= 3'(DEPTH), 1'b1);
  endtask

  task automatic update_model();
    int n;
    n = q.size();
    last_alu_rdy = (n < DEPTH);
    last_mem_rdy = (n < DEPTH - 1) || (n < DEPTH && !alu_valid);
    if (reset) begin
      q.delete();
    end else begin
      if (n > 0) void'(q.pop_front());
      if (alu_valid && last_alu_rdy && alu_dr != 5'd0)
        q.push_back('{alu_dr, alu_data});
      if (mem_valid && last_mem_rdy && mem_dr != 5'd0)
        q.push_back('{mem_dr, mem_data});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid = 1'b0; alu_dr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dr = '0; mem_data = '0;
  endtask

  task automatic rand_in(input bit force_valid);
    if (!(alu_valid && !last_alu_rdy)) begin
      alu_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
      alu_dr    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
    end
    if (!(mem_valid && !last_mem_rdy)) begin
      mem_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
      mem_dr    = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
    end
    sr1 = 5'($urandom_range(0, 7));
    sr2 = 5'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    sr1 = '0; sr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", write, 1'b0);
    chk("rst_dr", dr, 5'd0);
    chk("rst_wrData", wrData, 32'sd0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_mem_ready", mem_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_fwd1_hit", fwd1_hit, 1'b0);
    chk("rst_fwd2_hit", fwd2_hit, 1'b0);
    reset = 1'b0;
    cyc();

    // single ALU result
    alu_valid = 1'b1; alu_dr = 5'd5; alu_data = 32'sh0000_00AA;
    cyc();
    idle_in();
    chk("r028_write", write, 1'b1);
    chk("r028_dr", dr, 5'd5);
    chk("r028_wrData", wrData, 32'sh0000_00AA);
    cyc();
    chk("r028_empty", empty, 1'b1);

    // both ports, ALU ordered first
    alu_valid = 1'b1; alu_dr = 5'd3; alu_data = 32'sh11;
    mem_valid = 1'b1; mem_dr = 5'd4; mem_data = 32'sh22;
    cyc();
    idle_in();
    chk("r029_count", count, 3'd2);
    chk("r029_dr_first", dr, 5'd3);
    chk("r029_data_first", wrData, 32'sh11);
    cyc();
    chk("r029_dr_second", dr, 5'd4);
    chk("r029_data_second", wrData, 32'sh22);
    cyc();
    cyc();

    // dr == 0 on both ports is discarded
    alu_valid = 1'b1; alu_dr = 5'd0; alu_data = 32'sh55;
    mem_valid = 1'b1; mem_dr = 5'd0; mem_data = 32'sh66;
    cyc();
    idle_in();
    chk("r031_count", count, 3'd0);
    chk("r031_write", write, 1'b0);

    // bypass: two dr7 entries, younger wins
    alu_valid = 1'b1; alu_dr = 5'd7; alu_data = 32'sh10;
    mem_valid = 1'b1; mem_dr = 5'd7; mem_data = 32'sh20;
    cyc();
    idle_in();
    sr1 = 5'd7; sr2 = 5'd0;
    #1;
`ifdef WB_BYPASS_EN
    chk("r032_fwd1_hit", fwd1_hit, 1'b1);
    chk("r032_fwd1_data", fwd1_data, 32'sh20);
`else
    chk("r032_fwd1_hit", fwd1_hit, 1'b0);
    chk("r032_fwd1_data", fwd1_data, 32'sh0);
`endif
    chk("r032_fwd2_hit", fwd2_hit, 1'b0);
    chk("r032_fwd2_data", fwd2_data, 32'sh0);
    cyc();
    cyc();
    cyc();

    // build 3 entries, then reset with ALU valid
    alu_valid = 1'b1; alu_dr = 5'd1; alu_data = 32'sh1;
    mem_valid = 1'b1; mem_dr = 5'd2; mem_data = 32'sh2;
    cyc();
    alu_dr = 5'd3; alu_data = 32'sh3;
    mem_dr = 5'd4; mem_data = 32'sh4;
    cyc();
    mem_valid = 1'b0;
    chk("r033_pre_count", count, 3'd3);
    reset = 1'b1;
    alu_dr = 5'd9; alu_data = 32'sh9;
    cyc();
    reset = 1'b0;
    idle_in();
    chk("r033_count", count, 3'd0);
    chk("r033_write", write, 1'b0);
    cyc();

    // saturating traffic: both ports valid every cycle
    for (int i = 0; i < 60; i++) begin
      rand_in(1'b1);
      cyc();
    end
    idle_in();
    repeat (DEPTH + 1) cyc();
    chk("drain_empty", empty, 1'b1);

    // mixed random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rand_in(1'b0);
      reset = ($urandom_range(0, 63) == 0);
      cyc();
    end
    reset = 1'b0;
    idle_in();
    repeat (DEPTH + 1) cyc();
    chk("final_empty", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
